// File: rtl/exception_ctrl.sv
// Exception sequencer ahead of the PCSource mux: saves EPC, fetches the handler byte, loads PC, and handles eret.
// Optional cause register is built only when EXC_CAUSE_EN is defined; otherwise cause_out is tied to 2'b00.
module exception_ctrl #(
  parameter logic [31:0] VEC_BASE  = 32'd253,
  parameter logic [31:0] PC_OFFSET = 32'd4,
  parameter int          MEM_LAT   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        exc_opcode,
  input  logic        exc_ovf,
  input  logic        exc_div0,
  input  logic        eret,
  input  logic [31:0] pc_in,
  input  logic [7:0]  mem_data_in,
  output logic        mem_rd,
  output logic [31:0] mem_addr,
  output logic [31:0] epc_out,
  output logic [31:0] handler_out,
  output logic [1:0]  pcsrc_out,
  output logic        pc_wr,
  output logic        pc_ovr,
  output logic        busy,
  output logic [1:0]  cause_out
);

  localparam int CNT_W = (MEM_LAT > 1) ? $clog2(MEM_LAT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MEM_LAT - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SAVE,
    S_FETCH,
    S_LOAD,
    S_RET
  } state_t;

  state_t           state_q;
  logic [1:0]       code_q;
  logic [1:0]       code_d;
  logic             exc_req_d;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       byte_q;
  logic [31:0]      epc_q;
  logic [31:0]      mem_addr_q;
  logic             mem_rd_q;
  logic             pc_wr_q;
  logic             pc_ovr_q;
  logic [1:0]       pcsrc_q;
  logic             busy_q;
`ifdef EXC_CAUSE_EN
  logic [1:0]       cause_q;
`endif

  // Fixed priority: opcode > overflow > divide-by-zero; code doubles as the cause encoding.
  always_comb begin
    code_d = 2'b00;
    if (exc_opcode)    code_d = 2'b01;
    else if (exc_ovf)  code_d = 2'b10;
    else if (exc_div0) code_d = 2'b11;
  end

  assign exc_req_d = exc_opcode | exc_ovf | exc_div0;

  // Outputs are registered alongside the state so they change exactly when the state does.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      code_q     <= 2'b00;
      cnt_q      <= '0;
      byte_q     <= 8'h00;
      epc_q      <= 32'h0;
      mem_addr_q <= 32'h0;
      mem_rd_q   <= 1'b0;
      pc_wr_q    <= 1'b0;
      pc_ovr_q   <= 1'b0;
      pcsrc_q    <= 2'b00;
      busy_q     <= 1'b0;
`ifdef EXC_CAUSE_EN
      cause_q    <= 2'b00;
`endif
    end else begin
      case (state_q)
        S_IDLE: begin
          if (exc_req_d) begin
            code_q  <= code_d;
            busy_q  <= 1'b1;
            state_q <= S_SAVE;
          end else if (eret) begin
            pc_ovr_q <= 1'b1;
            pc_wr_q  <= 1'b1;
            pcsrc_q  <= 2'b01;
            busy_q   <= 1'b1;
            state_q  <= S_RET;
          end
        end
        S_SAVE: begin
          epc_q      <= pc_in - PC_OFFSET;
          cnt_q      <= '0;
          mem_rd_q   <= 1'b1;
          mem_addr_q <= VEC_BASE + 32'(code_q) - 32'd1;
`ifdef EXC_CAUSE_EN
          cause_q    <= code_q;
`endif
          state_q    <= S_FETCH;
        end
        S_FETCH: begin
          cnt_q <= cnt_q + CNT_W'(1);
          if (cnt_q == CNT_LAST) begin
            byte_q     <= mem_data_in;
            mem_rd_q   <= 1'b0;
            mem_addr_q <= 32'h0;
            pc_ovr_q   <= 1'b1;
            pc_wr_q    <= 1'b1;
            pcsrc_q    <= 2'b11;
            state_q    <= S_LOAD;
          end
        end
        S_LOAD, S_RET: begin
          pc_ovr_q <= 1'b0;
          pc_wr_q  <= 1'b0;
          pcsrc_q  <= 2'b00;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
        default: begin
          mem_rd_q <= 1'b0;
          pc_ovr_q <= 1'b0;
          pc_wr_q  <= 1'b0;
          pcsrc_q  <= 2'b00;
          busy_q   <= 1'b0;
          state_q  <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_rd      = mem_rd_q;
  assign mem_addr    = mem_addr_q;
  assign epc_out     = epc_q;
  assign handler_out = {24'h0, byte_q};
  assign pcsrc_out   = pcsrc_q;
  assign pc_wr       = pc_wr_q;
  assign pc_ovr      = pc_ovr_q;
  assign busy        = busy_q;
`ifdef EXC_CAUSE_EN
  assign cause_out   = cause_q;
`else
  assign cause_out   = 2'b00;
`endif

endmodule

// File: tb/tb_exception_ctrl.sv
// Directed bench for exception_ctrl with MEM_LAT=2 and a small vector-memory model.
module tb_exception_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        exc_opcode, exc_ovf, exc_div0, eret;
  logic [31:0] pc_in;
  logic [7:0]  mem_data_in;
  logic        mem_rd;
  logic [31:0] mem_addr;
  logic [31:0] epc_out;
  logic [31:0] handler_out;
  logic [1:0]  pcsrc_out;
  logic        pc_wr;
  logic        pc_ovr;
  logic        busy;
  logic [1:0]  cause_out;

  int checks = 0;
  int errors = 0;

`ifdef EXC_CAUSE_EN
  localparam bit CAUSE_ON = 1'b1;
`else
  localparam bit CAUSE_ON = 1'b0;
`endif

  exception_ctrl #(
    .VEC_BASE (32'd253),
    .PC_OFFSET(32'd4),
    .MEM_LAT  (2)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .exc_opcode (exc_opcode),
    .exc_ovf    (exc_ovf),
    .exc_div0   (exc_div0),
    .eret       (eret),
    .pc_in      (pc_in),
    .mem_data_in(mem_data_in),
    .mem_rd     (mem_rd),
    .mem_addr   (mem_addr),
    .epc_out    (epc_out),
    .handler_out(handler_out),
    .pcsrc_out  (pcsrc_out),
    .pc_wr      (pc_wr),
    .pc_ovr     (pc_ovr),
    .busy       (busy),
    .cause_out  (cause_out)
  );

  always #5 clk = ~clk;

  // Vector memory: opcode@253=A5, ovf@254=7C, div0@255=31.
  always_comb begin
    case (mem_addr)
      32'd253: mem_data_in = 8'hA5;
      32'd254: mem_data_in = 8'h7C;
      32'd255: mem_data_in = 8'h31;
      default: mem_data_in = 8'hEE;
    endcase
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1; exc_opcode = 0; exc_ovf = 0; exc_div0 = 0; eret = 0; pc_in = 32'h0;
    #1;
    checks++;
    if ({busy, pc_ovr, pc_wr, mem_rd, pcsrc_out, cause_out} !== 7'b0) begin
      errors++; $display("FAIL reset_strobes got %b want 0", {busy, pc_ovr, pc_wr, mem_rd, pcsrc_out, cause_out});
    end
    checks++;
    if (epc_out !== 32'h0 || handler_out !== 32'h0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_regs epc=%h handler=%h addr=%h want 0", epc_out, handler_out, mem_addr);
    end
    step(); step();
    reset = 1'b0;
    step();
    checks++;
    if (busy !== 1'b0 || pc_ovr !== 1'b0) begin
      errors++; $display("FAIL reset_idle busy=%b pc_ovr=%b want 0 0", busy, pc_ovr);
    end
  endtask

  task automatic test_ovf();
    int busy_cnt = 0;
    pc_in = 32'h40; exc_ovf = 1'b1;
    step(); exc_ovf = 1'b0;                   // SAVE
    if (busy) busy_cnt++;
    checks++;
    if (busy !== 1'b1 || mem_rd !== 1'b0 || pc_ovr !== 1'b0) begin
      errors++; $display("FAIL ovf_save busy=%b mem_rd=%b pc_ovr=%b want 1 0 0", busy, mem_rd, pc_ovr);
    end
    for (int i = 0; i < 2; i++) begin
      step();                                  // FETCH
      if (busy) busy_cnt++;
      checks++;
      if (mem_rd !== 1'b1 || mem_addr !== 32'd254 || epc_out !== 32'h3C || pc_wr !== 1'b0) begin
        errors++; $display("FAIL ovf_fetch%0d rd=%b addr=%0d epc=%h wr=%b want 1 254 3c 0", i, mem_rd, mem_addr, epc_out, pc_wr);
      end
    end
    step();                                    // LOAD
    if (busy) busy_cnt++;
    checks++;
    if (pc_ovr !== 1'b1 || pc_wr !== 1'b1 || pcsrc_out !== 2'b11 || handler_out !== 32'h7C || mem_rd !== 1'b0) begin
      errors++; $display("FAIL ovf_load ovr=%b wr=%b src=%b handler=%h rd=%b want 1 1 11 7c 0", pc_ovr, pc_wr, pcsrc_out, handler_out, mem_rd);
    end
    for (int i = 0; i < 2; i++) begin
      step();
      if (busy) busy_cnt++;
    end
    checks++;
    if (busy_cnt !== 4) begin
      errors++; $display("FAIL ovf_busy_cycles got %0d want 4", busy_cnt);
    end
    checks++;
    if (pc_ovr !== 1'b0 || pcsrc_out !== 2'b00 || handler_out !== 32'h7C) begin
      errors++; $display("FAIL ovf_idle ovr=%b src=%b handler=%h want 0 00 7c", pc_ovr, pcsrc_out, handler_out);
    end
  endtask

  task automatic test_eret();
    eret = 1'b1;
    step(); eret = 1'b0;                       // RET
    checks++;
    if (pc_ovr !== 1'b1 || pc_wr !== 1'b1 || pcsrc_out !== 2'b01 || epc_out !== 32'h3C || busy !== 1'b1) begin
      errors++; $display("FAIL eret_ret ovr=%b wr=%b src=%b epc=%h busy=%b want 1 1 01 3c 1", pc_ovr, pc_wr, pcsrc_out, epc_out, busy);
    end
    checks++;
    if (cause_out !== (CAUSE_ON ? 2'b10 : 2'b00)) begin
      errors++; $display("FAIL eret_cause got %b want %b", cause_out, (CAUSE_ON ? 2'b10 : 2'b00));
    end
    step();
    checks++;
    if (pc_ovr !== 1'b0 || pc_wr !== 1'b0 || busy !== 1'b0 || epc_out !== 32'h3C) begin
      errors++; $display("FAIL eret_idle ovr=%b wr=%b busy=%b epc=%h want 0 0 0 3c", pc_ovr, pc_wr, busy, epc_out);
    end
  endtask

  task automatic test_priority();
    pc_in = 32'h100; exc_opcode = 1'b1; exc_div0 = 1'b1;
    step(); exc_opcode = 1'b0; exc_div0 = 1'b0;  // SAVE
    step();                                      // FETCH
    checks++;
    if (mem_addr !== 32'd253 || epc_out !== 32'hFC) begin
      errors++; $display("FAIL prio_addr addr=%0d epc=%h want 253 fc", mem_addr, epc_out);
    end
    checks++;
    if (cause_out !== (CAUSE_ON ? 2'b01 : 2'b00)) begin
      errors++; $display("FAIL prio_cause got %b want %b", cause_out, (CAUSE_ON ? 2'b01 : 2'b00));
    end
    step(); step();                              // LOAD
    checks++;
    if (handler_out !== 32'hA5 || pcsrc_out !== 2'b11 || pc_wr !== 1'b1) begin
      errors++; $display("FAIL prio_load handler=%h src=%b wr=%b want a5 11 1", handler_out, pcsrc_out, pc_wr);
    end
    step();
  endtask

  task automatic test_div0_eret();
    pc_in = 32'h200; exc_div0 = 1'b1; eret = 1'b1;
    step(); exc_div0 = 1'b0; eret = 1'b0;        // SAVE, not RET
    checks++;
    if (pc_ovr !== 1'b0 || busy !== 1'b1) begin
      errors++; $display("FAIL d0eret_save ovr=%b busy=%b want 0 1", pc_ovr, busy);
    end
    step();
    checks++;
    if (mem_addr !== 32'd255 || mem_rd !== 1'b1) begin
      errors++; $display("FAIL d0eret_addr addr=%0d rd=%b want 255 1", mem_addr, mem_rd);
    end
    step(); step();                              // LOAD
    checks++;
    if (handler_out !== 32'h31 || pcsrc_out !== 2'b11) begin
      errors++; $display("FAIL d0eret_load handler=%h src=%b want 31 11", handler_out, pcsrc_out);
    end
    step();
    checks++;
    if (pc_ovr !== 1'b0 || busy !== 1'b0 || pcsrc_out !== 2'b00) begin
      errors++; $display("FAIL d0eret_noret ovr=%b busy=%b src=%b want 0 0 00", pc_ovr, busy, pcsrc_out);
    end
  endtask

  task automatic test_busy_ignore();
    pc_in = 32'h40; exc_ovf = 1'b1;
    step(); exc_ovf = 1'b0;                      // SAVE
    step(); exc_div0 = 1'b1;                     // FETCH, late request
    step(); exc_div0 = 1'b0;
    checks++;
    if (mem_addr !== 32'd254) begin
      errors++; $display("FAIL ignore_addr got %0d want 254", mem_addr);
    end
    step();                                      // LOAD
    checks++;
    if (handler_out !== 32'h7C || pc_wr !== 1'b1) begin
      errors++; $display("FAIL ignore_load handler=%h wr=%b want 7c 1", handler_out, pc_wr);
    end
    step(); step();
    checks++;
    if (busy !== 1'b0 || mem_rd !== 1'b0) begin
      errors++; $display("FAIL ignore_no_second busy=%b rd=%b want 0 0", busy, mem_rd);
    end
  endtask

  task automatic test_reset_mid();
    int wr_seen = 0;
    pc_in = 32'h80; exc_ovf = 1'b1;
    step(); exc_ovf = 1'b0;
    step();                                      // FETCH
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, pc_ovr, pc_wr, mem_rd, pcsrc_out, cause_out} !== 7'b0 || epc_out !== 32'h0 || mem_addr !== 32'h0) begin
      errors++; $display("FAIL rstmid_outs flags=%b epc=%h addr=%h want 0", {busy, pc_ovr, pc_wr, mem_rd, pcsrc_out, cause_out}, epc_out, mem_addr);
    end
    step();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      if (pc_wr) wr_seen++;
    end
    checks++;
    if (wr_seen !== 0 || busy !== 1'b0) begin
      errors++; $display("FAIL rstmid_nowr pc_wr_cycles=%0d busy=%b want 0 0", wr_seen, busy);
    end
    pc_in = 32'h0; exc_opcode = 1'b1;
    step(); exc_opcode = 1'b0;
    step();
    checks++;
    if (epc_out !== 32'hFFFFFFFC) begin
      errors++; $display("FAIL pc0_epc got %h want fffffffc", epc_out);
    end
    step(); step(); step();
  endtask

  initial begin
    test_reset();
    test_ovf();
    test_eret();
    test_priority();
    test_div0_eret();
    test_busy_ignore();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
